// File: rtl/pe_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pipe
//  Description : Two-stage pipelined processing element. Performs ADD, SUB,
//                MUL, MAC on unsigned W-bit operands and maintains an
//                internal RW-bit accumulator (ACC / read-and-clear CLR) with
//                saturating or wrapping overflow. Valid/ready handshakes on
//                both sides; up to two operations in flight.
//  Ports       : clk, rst                    - clock, sync active-high reset
//                in_valid/in_ready           - operation handshake
//                op_a, op_b, op_c [W-1:0]    - unsigned operands
//                op_i [3:0]                  - opcode (0..5 valid)
//                out_valid/out_ready         - result handshake
//                result [RW-1:0], ovf        - result and accumulator overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_pipe #(
    parameter int W   = 8,
    parameter int SAT = 1,
    localparam int RW = 2*W+1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  op_a,
    input  logic [W-1:0]  op_b,
    input  logic [W-1:0]  op_c,
    input  logic [3:0]    op_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] result,
    output logic          ovf
);

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_MUL = 4'd2;
    localparam logic [3:0] c_OP_MAC = 4'd3;
    localparam logic [3:0] c_OP_ACC = 4'd4;
    localparam logic [3:0] c_OP_CLR = 4'd5;
    localparam bit         c_SAT    = (SAT != 0);

    // Stage 1: captured operation
    logic          r_s1_valid;
    logic [W-1:0]  r_s1_a;
    logic [W-1:0]  r_s1_b;
    logic [W-1:0]  r_s1_c;
    logic [3:0]    r_s1_op;

    // Stage 2: result register (drives the outputs directly)
    logic          r_s2_valid;
    logic [RW-1:0] r_result;
    logic          r_ovf;

    logic [RW-1:0] r_acc;

    logic          w_s2_load;
    logic [2*W-1:0] w_prod;
    logic [RW:0]   w_acc_sum;
    logic [RW-1:0] w_res;
    logic          w_ovf;
    logic [RW-1:0] w_acc_nxt;

    // S1 may accept whenever its content is free or is moving into S2.
    assign in_ready  = !rst && !(r_s1_valid && r_s2_valid && !out_ready);
    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);

    assign w_prod    = {{W{1'b0}}, r_s1_a} * {{W{1'b0}}, r_s1_b};
    // One extra bit on top of the accumulator captures the carry-out.
    assign w_acc_sum = {1'b0, r_acc} + {{(RW+1-2*W){1'b0}}, w_prod};

    always_comb begin
        w_res     = '0;
        w_ovf     = 1'b0;
        w_acc_nxt = r_acc;
        case (r_s1_op)
            c_OP_ADD: w_res = {{(RW-W){1'b0}}, r_s1_a} + {{(RW-W){1'b0}}, r_s1_b};
            c_OP_SUB: w_res = {{(RW-W){1'b0}}, r_s1_a} - {{(RW-W){1'b0}}, r_s1_b};
            c_OP_MUL: w_res = {1'b0, w_prod};
            c_OP_MAC: w_res = {1'b0, w_prod} + {{(RW-W){1'b0}}, r_s1_c};
            c_OP_ACC: begin
                if (w_acc_sum[RW]) begin
                    w_ovf     = 1'b1;
                    w_acc_nxt = c_SAT ? {RW{1'b1}} : w_acc_sum[RW-1:0];
                end else begin
                    w_acc_nxt = w_acc_sum[RW-1:0];
                end
                w_res = w_acc_nxt;
            end
            c_OP_CLR: begin
                w_res     = r_acc;
                w_acc_nxt = '0;
            end
            default: begin
                w_res     = '0;
                w_ovf     = 1'b0;
                w_acc_nxt = r_acc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s1_op    <= '0;
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_acc      <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                r_s1_a     <= op_a;
                r_s1_b     <= op_b;
                r_s1_c     <= op_c;
                r_s1_op    <= op_i;
            end
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_result   <= w_res;
                r_ovf      <= w_ovf;
                // Accumulator only advances as its op leaves S1, keeping
                // ACC/CLR effects strictly in acceptance order.
                r_acc      <= w_acc_nxt;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pe_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_pipe
//  Description : Testbench for pe_pipe. Two instances (saturating and
//                wrapping) share one stimulus stream and are compared every
//                cycle against a queue-based reference model, with a few
//                literal expectations for the documented example cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_pipe;

    localparam int  W    = 8;
    localparam int  RW   = 2*W+1;
    localparam longint MODV = 131072;
    localparam longint MAXV = 131071;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  op_a, op_b, op_c;
    logic [3:0]    op_i;
    logic          out_ready;

    logic          ir1, ir0, ov1, ov0, of1, of0;
    logic [RW-1:0] res1, res0;

    always #5 clk = ~clk;

    pe_pipe #(.W(W), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_i(op_i),
        .out_valid(ov1), .out_ready(out_ready), .result(res1), .ovf(of1)
    );

    pe_pipe #(.W(W), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_i(op_i),
        .out_valid(ov0), .out_ready(out_ready), .result(res0), .ovf(of0)
    );

    typedef struct {
        longint r1;
        longint r0;
        bit     o1;
        bit     o0;
        int     e;
    } exp_t;

    exp_t   q[$];
    longint acc1 = 0;
    longint acc0 = 0;
    int     edge_cnt = 0;
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference semantics of one operation, in plain integer arithmetic.
    function automatic void eval(input int op, input longint a, input longint b,
                                 input longint c, input bit sat,
                                 inout longint acc, output longint res,
                                 output bit ovf);
        longint s;
        res = 0;
        ovf = 1'b0;
        case (op)
            0: res = a + b;
            1: res = (a - b + MODV) % MODV;
            2: res = a * b;
            3: res = a * b + c;
            4: begin
                s = acc + a * b;
                if (s > MAXV) begin
                    ovf = 1'b1;
                    acc = sat ? MAXV : s - MODV;
                end else begin
                    acc = s;
                end
                res = acc;
            end
            5: begin
                res = acc;
                acc = 0;
            end
            default: res = 0;
        endcase
    endfunction

    // One clock cycle: drive, check outputs against the model, advance model.
    task automatic step(input bit r, input bit iv, input int op, input int a,
                        input int b, input int c, input bit ordy);
        bit   exp_ir, exp_ov, take, cons;
        exp_t ent;
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        op_i      = op[3:0];
        op_a      = a[W-1:0];
        op_b      = b[W-1:0];
        op_c      = c[W-1:0];
        out_ready = ordy;
        #1;
        exp_ir = !r && !(q.size() == 2 && !ordy);
        exp_ov = (q.size() > 0) && (q[0].e < edge_cnt);
        chk("in_ready_sat", ir1, exp_ir);
        chk("in_ready_wrap", ir0, exp_ir);
        chk("out_valid_sat", ov1, exp_ov);
        chk("out_valid_wrap", ov0, exp_ov);
        if (exp_ov) begin
            chk("result_sat", res1, q[0].r1);
            chk("ovf_sat", of1, q[0].o1);
            chk("result_wrap", res0, q[0].r0);
            chk("ovf_wrap", of0, q[0].o0);
        end
        take = iv && exp_ir;
        cons = exp_ov && ordy;
        @(posedge clk);
        edge_cnt++;
        if (r) begin
            q.delete();
            acc1 = 0;
            acc0 = 0;
        end else begin
            if (cons) void'(q.pop_front());
            if (take) begin
                eval(op & 15, a & 255, b & 255, c & 255, 1'b1, acc1, ent.r1, ent.o1);
                eval(op & 15, a & 255, b & 255, c & 255, 1'b0, acc0, ent.r0, ent.o0);
                ent.e = edge_cnt;
                q.push_back(ent);
            end
        end
    endtask

    // Literal expectation for the result currently held in S2.
    task automatic lit(input string nm, input longint r1, input bit o1,
                       input longint r0, input bit o0);
        #2;
        chk({nm, "_valid"}, ov1 && ov0, 1);
        chk({nm, "_res_sat"}, res1, r1);
        chk({nm, "_ovf_sat"}, of1, o1);
        chk({nm, "_res_wrap"}, res0, r0);
        chk({nm, "_ovf_wrap"}, of0, o0);
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 0, 0, 0, 0, ordy);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_c = '0;
        op_i = '0; out_ready = 1'b1;

        // Reset with an operation offered: must not be accepted.
        step(1, 1, 0, 9, 9, 0, 1);
        step(1, 1, 4, 9, 9, 0, 1);
        #2;
        chk("rst_out_valid", ov1 || ov0, 0);
        chk("rst_result", res1 | res0, 0);
        chk("rst_ovf", of1 || of0, 0);

        // Arithmetic examples
        step(0, 1, 0, 200, 100, 0, 1);
        idle(1);
        lit("add", 'h12C, 0, 'h12C, 0);
        step(0, 1, 1, 5, 7, 0, 1);
        step(0, 1, 3, 255, 255, 255, 1);
        lit("sub", 'h1FFFE, 0, 'h1FFFE, 0);
        step(0, 1, 9, 3, 4, 5, 1);
        lit("mac", 'h0FF00, 0, 'h0FF00, 0);
        idle(1);
        lit("invalid", 0, 0, 0, 0);
        idle(1);

        // Backpressure: third ADD must be refused while the output stalls.
        step(0, 1, 0, 1, 2, 0, 0);
        step(0, 1, 0, 3, 4, 0, 0);
        step(0, 1, 0, 5, 6, 0, 0);
        lit("bp_hold", 3, 0, 3, 0);
        chk("bp_in_ready", ir1, 0);
        step(0, 1, 0, 5, 6, 0, 0);
        lit("bp_hold2", 3, 0, 3, 0);
        step(0, 1, 0, 5, 6, 0, 1);
        idle(1);
        idle(1);
        idle(1);

        // Accumulator: saturating vs wrapping, then read-and-clear.
        step(0, 1, 5, 0, 0, 0, 1);
        step(0, 1, 4, 255, 255, 0, 1);
        step(0, 1, 4, 255, 255, 0, 1);
        lit("acc1", 65025, 0, 65025, 0);
        step(0, 1, 4, 255, 255, 0, 1);
        lit("acc2", 130050, 0, 130050, 0);
        step(0, 1, 5, 0, 0, 0, 1);
        lit("acc3", 131071, 1, 64003, 1);
        step(0, 1, 4, 1, 1, 0, 1);
        lit("clr", 131071, 0, 64003, 0);
        idle(1);
        lit("acc_after_clr", 1, 0, 1, 0);
        idle(1);

        // Reset with two ops in flight and a nonzero accumulator.
        step(0, 1, 4, 2, 3, 0, 0);
        step(0, 1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        #2;
        chk("midrst_out_valid", ov1 || ov0, 0);
        step(0, 1, 4, 1, 1, 0, 1);
        idle(1);
        lit("acc_post_rst", 1, 0, 1, 0);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, iv, ordy;
            int op, a, b;
            r    = ($urandom_range(0, 99) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            op   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                               : int'($urandom_range(0, 5));
            a    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(200, 255))
                                               : int'($urandom_range(0, 255));
            b    = int'($urandom_range(0, 255));
            ordy = ($urandom_range(0, 2) != 0);
            step(r, iv, op, a, b, int'($urandom_range(0, 255)), ordy);
        end
        for (int i = 0; i < 4; i++) idle(1);
        chk("drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
